// File: rtl/ball_tick_gen.sv
// -----------------------------------------------------------------------------
// ball_tick_gen
//
// Generates the one-cycle ball-step strobe for the ball position stage. After
// b_rst is released the ball is held for SERVE_DELAY cycles. After that a step
// pulse is issued every period+1 cycles. The block watches ball_posx on every
// step to detect paddle returns (x direction reversals). Each hit extends the
// rally. Every SPEEDUP_EVERY hits the step period shrinks by STEP, down to
// MIN_PERIOD.
//
// Optional feature: define BALL_TICK_PAUSE_EN to add the pause port and the
// PAUSED state. While pause is high, every counter and the x history freeze.
//
// Ports:
//   clk           in   1   system clock
//   b_rst         in   1   asynchronous active-low reset (new point / game)
//   ball_posx     in  11   current ball x coordinate
//   pause         in   1   freeze request (only with BALL_TICK_PAUSE_EN)
//   tick          out  1   registered one-cycle ball-step strobe
//   serve_active  out  1   high while the ball is held for serve
//   rally_cnt     out  8   paddle hits since reset, saturating at 255
//   period        out 32   current step period value
// -----------------------------------------------------------------------------
module ball_tick_gen #(
  parameter int unsigned SERVE_DELAY   = 50000000,
  parameter int unsigned BASE_PERIOD   = 100000,
  parameter int unsigned MIN_PERIOD    = 40000,
  parameter int unsigned STEP          = 2000,
  parameter int unsigned SPEEDUP_EVERY = 4
) (
  input  logic        clk,
  input  logic        b_rst,
  input  logic [10:0] ball_posx,
`ifdef BALL_TICK_PAUSE_EN
  input  logic        pause,
`endif
  output logic        tick,
  output logic        serve_active,
  output logic [7:0]  rally_cnt,
  output logic [31:0] period
);

`ifdef BALL_TICK_PAUSE_EN
  typedef enum logic [1:0] {SERVE, PLAY, PAUSED} state_t;
`else
  typedef enum logic [1:0] {SERVE, PLAY} state_t;
`endif

  state_t      state;
  state_t      run_state;    // state whose action runs this cycle
  logic        frozen;

  logic [31:0] serve_cnt;
  logic [31:0] step_cnt;
  logic [31:0] hit_phase;    // hits so far, modulo SPEEDUP_EVERY
  logic [10:0] x_prev;
  logic [10:0] x_cur;
  logic        prev_valid;
  logic        cur_valid;

  logic signed [11:0] d_old;
  logic signed [11:0] d_new;
  logic               hit;

`ifdef BALL_TICK_PAUSE_EN
  state_t saved_state;

  // A PAUSED state with pause low resumes at once. The state it left performs
  // its normal action in the same cycle, so each frozen edge delays the
  // schedule by exactly one cycle.
  always_comb begin
    frozen    = pause;
    run_state = (state == PAUSED) ? saved_state : state;
  end
`else
  always_comb begin
    frozen    = 1'b0;
    run_state = state;
  end
`endif

  // Direction reversal: the previous step and the incoming step have
  // opposite, nonzero x deltas.
  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    d_old = $signed({1'b0, x_cur})     - $signed({1'b0, x_prev});
    d_new = $signed({1'b0, ball_posx}) - $signed({1'b0, x_cur});
    hit   = 1'b0;
    if (prev_valid && cur_valid) begin
      hit = ((d_old > 12'sd0) && (d_new < 12'sd0)) ||
            ((d_old < 12'sd0) && (d_new > 12'sd0));
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge b_rst) begin
    if (!b_rst) begin
      state        <= SERVE;
`ifdef BALL_TICK_PAUSE_EN
      saved_state  <= SERVE;
`endif
      serve_active <= 1'b1;
      tick         <= 1'b0;
      rally_cnt    <= 8'd0;
      period       <= BASE_PERIOD;
      serve_cnt    <= 32'd0;
      step_cnt     <= 32'd0;
      hit_phase    <= 32'd0;
      x_prev       <= 11'd0;
      x_cur        <= 11'd0;
      prev_valid   <= 1'b0;
      cur_valid    <= 1'b0;
    end else begin
      // History and hit handling run on the edge that ends the tick cycle.
      // By then the step counter has already been cleared, so a new period
      // applies to the interval that has just started. A tick cycle that
      // coincides with a pause request still completes its history update.
      if (tick) begin
        x_prev     <= x_cur;
        prev_valid <= cur_valid;
        x_cur      <= ball_posx;
        cur_valid  <= 1'b1;
        if (hit && (rally_cnt != 8'hFF)) begin
          rally_cnt <= rally_cnt + 8'd1;
          if (hit_phase == SPEEDUP_EVERY - 1) begin
            hit_phase <= 32'd0;
            // Guard the subtraction so the period cannot drop below the floor.
            if (period < STEP + MIN_PERIOD) begin
              period <= MIN_PERIOD;
            end else begin
              period <= period - STEP;
            end
          end else begin
            hit_phase <= hit_phase + 32'd1;
          end
        end
      end

      if (frozen) begin
        tick <= 1'b0;
`ifdef BALL_TICK_PAUSE_EN
        if (state != PAUSED) begin
          saved_state <= state;
        end
        state <= PAUSED;
`endif
      end else begin
        state <= run_state;
        case (run_state)
          SERVE: begin
            tick <= 1'b0;
            if (serve_cnt == SERVE_DELAY - 1) begin
              state        <= PLAY;
              serve_active <= 1'b0;
              step_cnt     <= 32'd0;
            end else begin
              serve_cnt <= serve_cnt + 32'd1;
            end
          end
          PLAY: begin
            if (step_cnt == period) begin
              tick     <= 1'b1;
              step_cnt <= 32'd0;
            end else begin
              tick     <= 1'b0;
              step_cnt <= step_cnt + 32'd1;
            end
          end
          default: begin
            tick  <= 1'b0;
            state <= SERVE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/ball_tick_gen.md
# ball_tick_gen

Generates the ball-step strobe that advances the ball position stage, replacing a fixed-rate divider with a serve/rally-aware one. Each time the referee pulls `b_rst` low (new point or game reset), the block restarts. It holds the ball for a serve delay, then issues one-cycle step pulses whose period shrinks as the rally lengthens. It watches the ball x coordinate to detect paddle returns (direction reversals), and reports rally length and current step period for display and rule logic.

## Interface
- `SERVE_DELAY`, 50000000: clk cycles the ball is held after reset release.
- `BASE_PERIOD`, 100000: initial step period value.
- `MIN_PERIOD`, 40000: floor for the step period value.
- `STEP`, 2000: period reduction per speed-up.
- `SPEEDUP_EVERY`, 4: number of hits per speed-up; must be ≥1.

Ports:
- `clk`  in  1  system clock.
- `b_rst`  in  1  reset, asynchronous, active-low.
- `ball_posx`  in  11  current ball x coordinate from the ball position stage.
- `pause`  in  1  freeze request; present only with `BALL_TICK_PAUSE_EN`.
- `tick`  out  1  registered one-cycle ball-step strobe.
- `serve_active`  out  1  high while the ball is held for serve.
- `rally_cnt`  out  8  paddle hits since reset, saturating.
- `period`  out  32  current step period value.

## Operation
- States: SERVE, PLAY, plus PAUSED when `BALL_TICK_PAUSE_EN` is defined.
- Reset values (`b_rst` low, asynchronous):
  - state SERVE, `serve_active`=1, `tick`=0, `rally_cnt`=0, `period`=BASE_PERIOD.
  - Internal counters are 0 and both x-history valid flags are clear.
- SERVE:
  - A 32-bit serve counter increments once per clk. `tick` stays 0.
  - When the counter equals SERVE_DELAY-1, go to PLAY, clear `serve_active`, and zero the step counter.
- PLAY:
  - A 32-bit step counter counts 0..`period`.
  - In the cycle where it equals `period`, `tick`=1 and the counter returns to 0. Otherwise `tick`=0.
- Hit detection, evaluated on each `tick` cycle:
  - Each tick cycle shifts `x_prev<=x_cur` and `x_cur<=ball_posx`, with valid flags.
  - A hit is flagged when both history entries are valid and sign(`x_cur`-`x_prev`) and sign(`ball_posx`-`x_cur`) are opposite and both nonzero.
- On a hit:
  - `rally_cnt` increments, saturating at 255.
  - If the incremented value (pre-saturation) mod SPEEDUP_EVERY = 0, then `period` <= max(`period`-STEP, MIN_PERIOD). Compute the subtraction with underflow guard: if `period` < STEP+MIN_PERIOD, load MIN_PERIOD.
- Once saturated, `rally_cnt` stays at 255 and no further speed-ups occur.
- A change to `period` takes effect from the next step interval, because the counter was just cleared.
- Reset mid-operation: `b_rst` low in any state forces the reset values immediately, with no pending `tick`.

## Timing
- The first `tick` occurs SERVE_DELAY+`period` clk cycles after the first rising clk edge with `b_rst` high.
- Subsequent ticks are spaced `period`+1 cycles apart.
- `rally_cnt` and `period` update on the clock edge ending the tick cycle in which the hit is detected.
- `tick` is never high on two consecutive cycles, because `period` ≥ MIN_PERIOD ≥ 1 is required.

## Configuration
- `BALL_TICK_PAUSE_EN` defined:
  - The `pause` port exists.
  - `pause`=1 in SERVE or PLAY enters PAUSED, freezing all counters and history, with `tick`=0. `serve_active` holds its value.
  - `pause`=0 returns to the saved state, and counting resumes from the frozen value.
  - `pause` is sampled on each clk edge.
- Undefined: no `pause` port, no PAUSED state; behaviour is otherwise identical.

## Test plan
Parameters for all scenarios: SERVE_DELAY=10, BASE_PERIOD=7, MIN_PERIOD=3, STEP=2, SPEEDUP_EVERY=2.
- Release `b_rst` -> `serve_active`=1 for 10 cycles, first `tick` 17 cycles after the first edge, then one `tick` every 8 cycles, `period`=7.
- Present `ball_posx` 60, 61, 62, 61 on successive ticks -> hit on the fourth tick, `rally_cnt`=1, `period` stays 7.
- Produce 2 hits -> `period`=5 and spacing 6; produce 4 hits -> `period`=3; produce 6 hits -> `period` stays 3.
- Drive 300 alternating reversals -> `rally_cnt` saturates at 255 with no wrap.
- Pull `b_rst` low mid-PLAY with `rally_cnt`=3 -> same cycle `tick`=0, `rally_cnt`=0, `period`=7, `serve_active`=1.
- With `BALL_TICK_PAUSE_EN`:
  - `pause` high for 20 cycles in PLAY -> no ticks; the next `tick` arrives after exactly the remaining pre-pause count.
  - `pause` during SERVE extends the serve hold by 20 cycles.
